// File: rtl/ssooo_pkg.sv
// ssooo_pkg: definitions shared by the out-of-order core blocks.
//   - field widths: OPC_W, REG_W, ROBEN_W, DATA_W
//   - decoded opcode constants used by decode, issue and the ROB
//   - instq_entry_t: one decoded instruction as carried by inst_queue
package ssooo_pkg;

    localparam int OPC_W   = 12;
    localparam int REG_W   = 5;
    localparam int ROBEN_W = 5;
    localparam int DATA_W  = 32;

    // Control-flow and memory opcodes that later stages decode specially.
    localparam logic [OPC_W-1:0] hlt_inst = 12'h3F0;
    localparam logic [OPC_W-1:0] beq      = 12'h100;
    localparam logic [OPC_W-1:0] bne      = 12'h140;
    localparam logic [OPC_W-1:0] jal      = 12'h0C0;
    localparam logic [OPC_W-1:0] jr       = 12'h008;
    localparam logic [OPC_W-1:0] j        = 12'h080;
    localparam logic [OPC_W-1:0] lw       = 12'h8C0;
    localparam logic [OPC_W-1:0] sw       = 12'hAC0;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic              pred;
        logic [DATA_W-1:0] target;
    } instq_entry_t;

endpackage

// File: rtl/instq_ptr_ctrl.sv
// instq_ptr_ctrl: read/write pointers and occupancy for inst_queue.
//   clk, rst      clock; asynchronous active-high reset
//   flush_i       clears pointers and count; wins over push and pop
//   push_req_i    producer wants to write (gated here by full)
//   pop_req_i     consumer wants to read (gated here by empty)
//   push_en_o     a write happens this cycle (storage write enable)
//   wr_ptr_o      write address; rd_ptr_o read (head) address
//   count_o       occupancy 0..DEPTH; full_o / empty_o derived from it
module instq_ptr_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_req_i,
    input  logic          pop_req_i,
    output logic          push_en_o,
    output logic [AW-1:0] wr_ptr_o,
    output logic [AW-1:0] rd_ptr_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          push_en, pop_en;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);

    // Full is judged on the registered count only, so a pop in the same
    // cycle never opens the input: no combinational out_ready -> in_ready.
    assign push_en = push_req_i & ~full_o & ~flush_i;
    assign pop_en  = pop_req_i & ~empty_o & ~flush_i;

    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so AW-bit increments wrap to 0 naturally.
            if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push_en, pop_en})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops
    // update together from values sampled before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign push_en_o = push_en;
    assign wr_ptr_o  = wr_ptr_q;
    assign rd_ptr_o  = rd_ptr_q;
    assign count_o   = count_q;

endmodule

// File: rtl/inst_queue.sv
// inst_queue: decoded-instruction FIFO between decode and ROB/RS issue.
// Carries branch prediction and target; a mispredict flush empties it.
//   clk, rst         clock; asynchronous active-high reset
//   flush            empties the queue, drops a concurrent push
//   in_valid/ready   decode handshake; in_ready = not full
//   in_*             opcode, rs, rt, rd, imm, pc, pred, target
//   out_valid/ready  issue handshake; head entry on out_* (combinational)
//   count            occupancy 0..DEPTH
// Build option INSTQ_BYPASS_EN: when empty, an offered instruction is
// passed straight to out_* in the same cycle and is not stored if taken.
module inst_queue
    import ssooo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  in_opcode,
    input  logic [REG_W-1:0]  in_rs,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              in_pred,
    input  logic [DATA_W-1:0] in_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OPC_W-1:0]  out_opcode,
    output logic [REG_W-1:0]  out_rs,
    output logic [REG_W-1:0]  out_rt,
    output logic [REG_W-1:0]  out_rd,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_pc,
    output logic              out_pred,
    output logic [DATA_W-1:0] out_target,
    output logic [AW:0]       count
);

    instq_entry_t  mem [DEPTH];
    instq_entry_t  in_entry, head_entry, out_entry;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push_req, pop_req, push_en;
    logic          full, empty;

    assign in_entry = '{opcode: in_opcode, rs: in_rs, rt: in_rt, rd: in_rd,
                        imm: in_imm, pc: in_pc, pred: in_pred, target: in_target};

    instq_ptr_ctrl #(.DEPTH(DEPTH), .AW(AW)) u_ptr_ctrl (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .push_req_i (push_req),
        .pop_req_i  (pop_req),
        .push_en_o  (push_en),
        .wr_ptr_o   (wr_ptr),
        .rd_ptr_o   (rd_ptr),
        .count_o    (count),
        .full_o     (full),
        .empty_o    (empty)
    );

    // NOTE: the storage array has no reset; entries are only observed
    // once count says they were written, so clearing them buys nothing.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= in_entry;
    end

    assign head_entry = mem[rd_ptr];
    assign in_ready   = ~full;

`ifdef INSTQ_BYPASS_EN
    logic bypass;
    // Empty queue and a live offer: present it now. If issue takes it this
    // cycle it must not also be written, otherwise it would come out twice.
    assign bypass    = empty & in_valid & ~flush;
    assign out_valid = ~empty | bypass;
    assign out_entry = bypass ? in_entry : head_entry;
    assign pop_req   = out_ready;
    assign push_req  = in_valid & ~(bypass & out_ready);
`else
    assign out_valid = ~empty;
    assign out_entry = head_entry;
    assign pop_req   = out_ready;
    assign push_req  = in_valid;
`endif

    assign out_opcode = out_entry.opcode;
    assign out_rs     = out_entry.rs;
    assign out_rt     = out_entry.rt;
    assign out_rd     = out_entry.rd;
    assign out_imm    = out_entry.imm;
    assign out_pc     = out_entry.pc;
    assign out_pred   = out_entry.pred;
    assign out_target = out_entry.target;

endmodule
